lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the core's execute/memory stage and the word-addressed data memory.
- Core side: accepts one load or store request per transaction over a valid/ready handshake and returns a response over valid/ready.
- Memory side: drives read enable, write enable, byte address and write data; receives combinational read data.
- Performs byte/halfword extraction with sign/zero extension, and read-modify-write for sub-word stores, because the memory only writes full words.

Parameters:
- DATA_WIDTH, 32, data bus width; the logic is defined for 32 only.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- resp_err  out  1  illegal or misaligned request.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  byte address to memory, always word-aligned (low 2 bits 0).
- mem_wdata  out  DATA_WIDTH  full-word write data.
- mem_rdata  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
  - All captured request registers cleared.
- States: IDLE, RD, WR, RESP.
  - req_ready=1 only in IDLE.
  - mem_read=1 only in RD; mem_write=1 only in WR.
  - All other cycles: mem_read=0, mem_write=0.
- Accept: req_valid && req_ready in IDLE captures we, funct3, addr, wdata. Next state:
  - Illegal funct3 -> RESP with err=1, no memory access.
    - Loads: 011, 110, 111 are illegal.
    - Stores: any value other than 000, 001, 010 is illegal.
  - Misaligned -> RESP with err=1, no memory access (see Optional Feature).
    - Half: addr[0]=1.
    - Word: addr[1:0]!=0.
  - Load or SB/SH -> RD.
  - SW -> WR.
- RD:
  - mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - mem_rdata registered at the clock edge.
  - Load -> RESP. SB/SH -> WR.
- WR:
  - SW: mem_wdata = wdata.
  - SB: registered read word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: lane addr[1] replaced by wdata[15:0].
  - Next state -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_valid && resp_ready -> IDLE.
- Load extraction:
  - Select byte/half by addr[1:0] / addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Latency, in cycles from the accept edge to the first resp_valid:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Throughput: no new request is accepted until the response handshake completes. Back-to-back requests: earliest next accept is the cycle after the response handshake.
- Address wrap: none; upper address bits pass through unchanged.
- Reset mid-transaction: the FSM aborts immediately, and any pending write is dropped. mem_write deasserts asynchronously with reset.
- req_valid while not in IDLE is ignored; the core must hold the request until req_ready.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned half/word requests return resp_err=1 after 1 cycle.
  - No memory access is made; resp_rdata=0.
- Undefined:
  - Misalignment is not checked.
  - addr low bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0), and the access proceeds normally.
  - resp_err is asserted only for illegal funct3.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write pulse with mem_addr=0x10, mem_wdata=0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, latency 2.
- After the above, SB addr 0x11 data 0x55 -> RD then WR with mem_wdata=0xDEAD55EF, latency 3. Then LB 0x11 -> 0x00000055; LBU 0x13 -> 0x000000DE; LB 0x13 -> 0xFFFFFFDE.
- SH addr 0x12 data 0x8001, then LH 0x12 -> 0xFFFF8001 and LHU 0x12 -> 0x00008001; word at 0x10 = 0x800155EF.
- LW addr 0x06 with LSU_MISALIGN_TRAP_EN -> resp_err=1 after 1 cycle, mem_read and mem_write never asserted. Without the macro -> reads word 0x04, resp_err=0.
- Hold resp_ready=0 for 5 cycles on a load -> resp_valid, resp_rdata and resp_err stable, req_ready=0 throughout; the next request is accepted only after the handshake.
- Assert rst_n=0 during WR of an SB -> mem_write drops immediately, memory word unchanged, all outputs at reset values, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the core memory stage and a
// word-addressed data memory. Handles sub-word load extraction and
// read-modify-write for byte/halfword stores.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// requests are answered with resp_err and no memory access; when undefined,
// the address is forced to natural alignment and the access proceeds.
module lsu_mem_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   state_e          state_q;
   logic            we_q;
   logic [2:0]      funct3_q;
   logic [1:0]      lane_q;
   logic [15:0]     wdata_q;

   logic                  size_w;
   logic                  size_h;
   logic                  illegal;
   logic                  acc_err;
   logic [ADDR_WIDTH-1:0] acc_addr;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                  misal;
`endif

   // Sign/zero extension of the addressed byte or halfword of a read word.
   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      unique case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lo[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{24{b[7]}}, b};
         3'b001:  load_ext = {{16{h[15]}}, h};
         3'b100:  load_ext = {24'd0, b};
         3'b101:  load_ext = {16'd0, h};
         default: load_ext = w;
      endcase
   endfunction

   // Insert store data into the addressed lane(s) of the read word.
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] lo, input logic [15:0] wd);
      logic [31:0] m;
      m = w;
      if (f3[1:0] == 2'b00) begin
         unique case (lo)
            2'd0:    m[7:0]   = wd[7:0];
            2'd1:    m[15:8]  = wd[7:0];
            2'd2:    m[23:16] = wd[7:0];
            default: m[31:24] = wd[7:0];
         endcase
      end else if (lo[1]) begin
         m[31:16] = wd;
      end else begin
         m[15:0] = wd;
      end
      store_merge = m;
   endfunction

   // Decode the incoming request: legality, alignment and effective address.
   always_comb begin
      size_h  = (req_funct3[1:0] == 2'b01);
      size_w  = (req_funct3[1:0] == 2'b10);
      illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                       : ((req_funct3[1:0] == 2'b11) | (req_funct3[2] & req_funct3[1]));
`ifdef LSU_MISALIGN_TRAP_EN
      misal    = (size_h & req_addr[0]) | (size_w & (req_addr[1:0] != 2'b00));
      acc_err  = illegal | misal;
      acc_addr = req_addr;
`else
      acc_err  = illegal;
      acc_addr = req_addr;
      if (size_h) begin
         acc_addr[0] = 1'b0;
      end else if (size_w) begin
         acc_addr[1:0] = 2'b00;
      end
`endif
   end

   // Transaction FSM; every memory and response output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         we_q       <= 1'b0;
         funct3_q   <= 3'd0;
         lane_q     <= 2'd0;
         wdata_q    <= 16'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  funct3_q  <= req_funct3;
                  lane_q    <= acc_addr[1:0];
                  wdata_q   <= req_wdata[15:0];
                  req_ready <= 1'b0;
                  if (acc_err) begin
                     state_q    <= StResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_we && size_w) begin
                     // Full-word store needs no read.
                     state_q   <= StWr;
                     mem_write <= 1'b1;
                     mem_addr  <= {acc_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_wdata <= req_wdata;
                  end else begin
                     state_q  <= StRd;
                     mem_read <= 1'b1;
                     mem_addr <= {acc_addr[ADDR_WIDTH-1:2], 2'b00};
                  end
               end
            end
            StRd: begin
               mem_read <= 1'b0;
               if (we_q) begin
                  // mem_wdata doubles as the register holding the merged read word.
                  state_q   <= StWr;
                  mem_write <= 1'b1;
                  mem_wdata <= store_merge(mem_rdata, funct3_q, lane_q, wdata_q);
               end else begin
                  state_q    <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_ext(mem_rdata, funct3_q, lane_q);
               end
            end
            StWr: begin
               mem_write  <= 1'b0;
               state_q    <= StResp;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            StResp: begin
               if (resp_ready) begin
                  state_q    <= StIdle;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
                  req_ready  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
